// File: rtl/hid_pkg.sv
// hid_pkg: constants and types shared by the HID keyboard event blocks.
//   - typ codes for the report source (NONE/KBD/MOUSE/GAMEPAD)
//   - boot-protocol rollover / error scancodes 0x01..0x03
//   - 18-bit event record {press, rpt, code[7:0], mod[7:0]}
//   - scan FSM state type and small set-membership helpers
package hid_pkg;

    localparam logic [1:0] TYP_NONE    = 2'd0;
    localparam logic [1:0] TYP_KBD     = 2'd1;
    localparam logic [1:0] TYP_MOUSE   = 2'd2;
    localparam logic [1:0] TYP_GAMEPAD = 2'd3;

    localparam logic [7:0] KEY_ERR_ROLLOVER = 8'h01;
    localparam logic [7:0] KEY_ERR_POSTFAIL = 8'h02;
    localparam logic [7:0] KEY_ERR_UNDEF    = 8'h03;

    localparam int EVT_W = 18;

    typedef struct packed {
        logic       press;
        logic       rpt;
        logic [7:0] code;
        logic [7:0] mod;
    } hid_evt_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_REL    = 2'd1,
        ST_PRS    = 2'd2,
        ST_COMMIT = 2'd3
    } scan_state_t;

    function automatic logic is_err_code(input logic [7:0] k);
        return (k == KEY_ERR_ROLLOVER) || (k == KEY_ERR_POSTFAIL) || (k == KEY_ERR_UNDEF);
    endfunction

    function automatic logic key_in_set(input logic [7:0] k, input logic [3:0][7:0] s);
        logic hit;
        hit = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (s[i] == k) hit = 1'b1;
        end
        return hit;
    endfunction

endpackage

// File: rtl/hid_evt_fifo.sv
// hid_evt_fifo: synchronous first-word-fall-through FIFO for key events.
// Ports:
//   usbclk, usbrst : clock, synchronous active-high reset
//   push, din      : write request and data
//   pop            : read request (ignored while empty)
//   dout, empty    : head entry (valid when !empty)
//   full           : no free entry
//   drop           : push refused this cycle (full and no pop)
module hid_evt_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 18
) (
    input  logic             usbclk,
    input  logic             usbrst,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             empty,
    output logic             full,
    output logic             drop
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             pop_ok;
    logic             push_ok;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop_ok  = pop && !empty;
    // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
    assign push_ok = push && (!full || pop_ok);
    assign drop    = push && !push_ok;
    assign dout    = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge usbclk) begin
        if (usbrst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge usbclk) begin
        if (push_ok) mem[wr_ptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/hid_key_events.sv
// hid_key_events: turns boot-protocol keyboard reports into press/release
// events by diffing each report against the previous one, queued in an
// event FIFO. Optional auto-repeat is built only when HID_KEY_REPEAT_EN
// is defined.
// Ports:
//   usbclk, usbrst          : clock, synchronous active-high reset
//   report, typ             : report strobe and device type (only KBD used)
//   key_modifiers, key1..4  : report fields, sampled on report
//   ev_valid/ev_ready       : event handshake at FIFO head
//   ev_press, ev_repeat,
//   ev_code, ev_mod         : head event fields (zero while !ev_valid)
//   overflow, ovf_clr       : sticky event-dropped flag and its clear
//
// state  | meaning
// IDLE   | waiting for a pending report (repeat pushes happen here)
// REL    | idx 0..3 over prev keys, release those missing from new set
// PRS    | idx 0..3 over new keys, press those missing from prev set
// COMMIT | prev set <= new set
module hid_key_events
    import hid_pkg::*;
#(
    parameter int FIFO_DEPTH   = 8,
    parameter int REPEAT_DELAY = 6000000,
    parameter int REPEAT_RATE  = 400000
) (
    input  logic       usbclk,
    input  logic       usbrst,
    input  logic       report,
    input  logic [1:0] typ,
    input  logic [7:0] key_modifiers,
    input  logic [7:0] key1,
    input  logic [7:0] key2,
    input  logic [7:0] key3,
    input  logic [7:0] key4,
    output logic       ev_valid,
    input  logic       ev_ready,
    output logic       ev_press,
    output logic       ev_repeat,
    output logic [7:0] ev_code,
    output logic [7:0] ev_mod,
    output logic       overflow,
    input  logic       ovf_clr
);

    if (FIFO_DEPTH < 2 || FIFO_DEPTH > 32 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0
        || REPEAT_DELAY < 1 || REPEAT_RATE < 1) begin : g_bad_param
        $error("hid_key_events: illegal parameter value");
    end

    scan_state_t     state, state_nxt;
    logic [1:0]      idx, idx_nxt;
    logic [3:0][7:0] pend_keys, cur_keys, prev_keys;
    logic [7:0]      pend_mod, cur_mod;
    logic            pend_valid;
    logic            accept;
    logic            start;
    logic            push;
    hid_evt_t        push_evt;
    logic [7:0]      scan_key;
    logic            dup;
    logic            fifo_empty, fifo_full, fifo_drop;
    logic [EVT_W-1:0] fifo_dout;
    hid_evt_t        head;

    // Reports carrying a rollover/error code are dropped before they reach pending.
    assign accept = report && (typ == TYP_KBD) && !is_err_code(key1) && !is_err_code(key2)
                    && !is_err_code(key3) && !is_err_code(key4);
    assign start  = pend_valid && ((state == ST_IDLE) || (state == ST_COMMIT));

`ifdef HID_KEY_REPEAT_EN
    logic [31:0] rpt_cnt;
    logic [7:0]  rpt_key;
    logic        rpt_active;
    logic        rpt_fire;

    // Expired timer waits at zero until the scan is back in IDLE.
    assign rpt_fire = rpt_active && (rpt_cnt == 32'd0) && (state == ST_IDLE);
`endif

    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        push      = 1'b0;
        push_evt  = '0;
        scan_key  = 8'd0;
        dup       = 1'b0;
        case (state)
            ST_IDLE: begin
                if (pend_valid) begin
                    state_nxt = ST_REL;
                    idx_nxt   = 2'd0;
                end
`ifdef HID_KEY_REPEAT_EN
                if (rpt_fire) begin
                    push     = 1'b1;
                    push_evt = '{press: 1'b1, rpt: 1'b1, code: rpt_key, mod: cur_mod};
                end
`endif
            end
            ST_REL: begin
                scan_key = prev_keys[idx];
                if (scan_key != 8'd0 && !key_in_set(scan_key, cur_keys)) begin
                    push     = 1'b1;
                    push_evt = '{press: 1'b0, rpt: 1'b0, code: scan_key, mod: cur_mod};
                end
                idx_nxt = idx + 2'd1;
                if (idx == 2'd3) state_nxt = ST_PRS;
            end
            ST_PRS: begin
                scan_key = cur_keys[idx];
                for (int j = 0; j < 3; j++) begin
                    if (j < int'(idx) && cur_keys[j] == scan_key) dup = 1'b1;
                end
                if (scan_key != 8'd0 && !dup && !key_in_set(scan_key, prev_keys)) begin
                    push     = 1'b1;
                    push_evt = '{press: 1'b1, rpt: 1'b0, code: scan_key, mod: cur_mod};
                end
                idx_nxt = idx + 2'd1;
                if (idx == 2'd3) state_nxt = ST_COMMIT;
            end
            ST_COMMIT: begin
                state_nxt = pend_valid ? ST_REL : ST_IDLE;
                idx_nxt   = 2'd0;
            end
            default: begin
                state_nxt = ST_IDLE;
                idx_nxt   = 2'd0;
            end
        endcase
    end

    always_ff @(posedge usbclk) begin
        if (usbrst) begin
            state      <= ST_IDLE;
            idx        <= 2'd0;
            pend_valid <= 1'b0;
            pend_keys  <= '0;
            pend_mod   <= 8'd0;
            cur_keys   <= '0;
            cur_mod    <= 8'd0;
            prev_keys  <= '0;
            overflow   <= 1'b0;
        end else begin
            state <= state_nxt;
            idx   <= idx_nxt;
            // A new report in the same cycle as start replaces what start consumed.
            if (accept) begin
                pend_keys  <= {key4, key3, key2, key1};
                pend_mod   <= key_modifiers;
                pend_valid <= 1'b1;
            end else if (start) begin
                pend_valid <= 1'b0;
            end
            if (start) begin
                cur_keys <= pend_keys;
                cur_mod  <= pend_mod;
            end
            if (state == ST_COMMIT) prev_keys <= cur_keys;
            if (fifo_drop)    overflow <= 1'b1;
            else if (ovf_clr) overflow <= 1'b0;
        end
    end

`ifdef HID_KEY_REPEAT_EN
    always_ff @(posedge usbclk) begin
        if (usbrst) begin
            rpt_cnt    <= 32'd0;
            rpt_key    <= 8'd0;
            rpt_active <= 1'b0;
        end else begin
            if (rpt_fire)
                rpt_cnt <= 32'(REPEAT_RATE - 1);
            else if (rpt_active && rpt_cnt != 32'd0)
                rpt_cnt <= rpt_cnt - 32'd1;
            if (push && state == ST_REL && push_evt.code == rpt_key)
                rpt_active <= 1'b0;
            if (push && state == ST_PRS) begin
                rpt_active <= 1'b1;
                rpt_key    <= push_evt.code;
                rpt_cnt    <= 32'(REPEAT_DELAY - 1);
            end
        end
    end
`endif

    hid_evt_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (EVT_W)
    ) u_fifo (
        .usbclk (usbclk),
        .usbrst (usbrst),
        .push   (push),
        .din    (push_evt),
        .pop    (ev_valid && ev_ready),
        .dout   (fifo_dout),
        .empty  (fifo_empty),
        .full   (fifo_full),
        .drop   (fifo_drop)
    );

    // The rpt bit is only ever written as 1 when auto-repeat is built in.
    assign head      = fifo_dout;
    assign ev_valid  = !fifo_empty;
    assign ev_press  = ev_valid && head.press;
    assign ev_repeat = ev_valid && head.rpt;
    assign ev_code   = ev_valid ? head.code : 8'd0;
    assign ev_mod    = ev_valid ? head.mod  : 8'd0;

endmodule

// File: tb/tb_hid_key_events.sv
module tb_hid_key_events;

    logic usbclk = 1'b0;
    always #5 usbclk = ~usbclk;

    logic       usbrst = 1'b1;
    logic [1:0] typ = 2'd0;
    logic [7:0] key_modifiers = 8'd0, key1 = 8'd0, key2 = 8'd0, key3 = 8'd0, key4 = 8'd0;

    logic a_report = 1'b0, a_ready = 1'b0, a_ovf_clr = 1'b0;
    logic a_valid, a_press, a_repeat, a_ovf;
    logic [7:0] a_code, a_mod;

    logic b_report = 1'b0, b_ready = 1'b0, b_ovf_clr = 1'b0;
    logic b_valid, b_press, b_repeat, b_ovf;
    logic [7:0] b_code, b_mod;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    always @(posedge usbclk) cyc <= cyc + 1;

    hid_key_events #(.FIFO_DEPTH(8)) u_dut_a (
        .usbclk(usbclk), .usbrst(usbrst), .report(a_report), .typ(typ),
        .key_modifiers(key_modifiers), .key1(key1), .key2(key2), .key3(key3), .key4(key4),
        .ev_valid(a_valid), .ev_ready(a_ready), .ev_press(a_press), .ev_repeat(a_repeat),
        .ev_code(a_code), .ev_mod(a_mod), .overflow(a_ovf), .ovf_clr(a_ovf_clr));

    hid_key_events #(.FIFO_DEPTH(2)) u_dut_b (
        .usbclk(usbclk), .usbrst(usbrst), .report(b_report), .typ(typ),
        .key_modifiers(key_modifiers), .key1(key1), .key2(key2), .key3(key3), .key4(key4),
        .ev_valid(b_valid), .ev_ready(b_ready), .ev_press(b_press), .ev_repeat(b_repeat),
        .ev_code(b_code), .ev_mod(b_mod), .overflow(b_ovf), .ovf_clr(b_ovf_clr));

`ifdef HID_KEY_REPEAT_EN
    logic c_report = 1'b0, c_ready = 1'b1, c_ovf_clr = 1'b0;
    logic c_valid, c_press, c_repeat, c_ovf;
    logic [7:0] c_code, c_mod;
    int c_t[$];
    logic [9:0] c_e[$];

    hid_key_events #(.FIFO_DEPTH(8), .REPEAT_DELAY(20), .REPEAT_RATE(5)) u_dut_c (
        .usbclk(usbclk), .usbrst(usbrst), .report(c_report), .typ(typ),
        .key_modifiers(key_modifiers), .key1(key1), .key2(key2), .key3(key3), .key4(key4),
        .ev_valid(c_valid), .ev_ready(c_ready), .ev_press(c_press), .ev_repeat(c_repeat),
        .ev_code(c_code), .ev_mod(c_mod), .overflow(c_ovf), .ovf_clr(c_ovf_clr));

    initial forever begin
        @(negedge usbclk); #2;
        if (!usbrst && c_valid) begin
            c_t.push_back(cyc);
            c_e.push_back({c_press, c_repeat, c_code});
        end
    end
`endif

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Reference model: per report, releases of vanished keys then presses of
    // new keys, both in slot order; error-coded reports change nothing.
    logic [7:0]  m_prev [4] = '{default: 8'd0};
    logic [16:0] exp_q[$];

    function automatic bit in_list(input logic [7:0] k, input logic [7:0] l [4]);
        for (int i = 0; i < 4; i++) if (l[i] == k) return 1'b1;
        return 1'b0;
    endfunction

    task automatic model_report(input logic [7:0] md, input logic [31:0] keys);
        logic [7:0] nk [4];
        bit dup;
        for (int i = 0; i < 4; i++) nk[i] = keys[8*i +: 8];
        for (int i = 0; i < 4; i++) if (nk[i] >= 8'd1 && nk[i] <= 8'd3) return;
        for (int i = 0; i < 4; i++)
            if (m_prev[i] != 8'd0 && !in_list(m_prev[i], nk)) exp_q.push_back({1'b0, m_prev[i], md});
        for (int i = 0; i < 4; i++) begin
            dup = 1'b0;
            for (int j = 0; j < i; j++) if (nk[j] == nk[i]) dup = 1'b1;
            if (nk[i] != 8'd0 && !dup && !in_list(nk[i], m_prev)) exp_q.push_back({1'b1, nk[i], md});
        end
        m_prev = nk;
    endtask

    // which: 0 = A, 1 = B, 2 = C. mdl: feed the report to the A model.
    task automatic send(input int which, input logic [1:0] t, input logic [7:0] md,
                        input logic [31:0] keys, input bit mdl);
        @(negedge usbclk);
        typ = t;
        key_modifiers = md;
        {key4, key3, key2, key1} = keys;
        if (which == 0) a_report = 1'b1;
        else if (which == 1) b_report = 1'b1;
`ifdef HID_KEY_REPEAT_EN
        else c_report = 1'b1;
`endif
        @(negedge usbclk);
        a_report = 1'b0;
        b_report = 1'b0;
`ifdef HID_KEY_REPEAT_EN
        c_report = 1'b0;
`endif
        if (which == 0 && mdl && t == 2'd1) model_report(md, keys);
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 300) begin
            @(negedge usbclk);
            n++;
        end
        check("drain_pending", exp_q.size(), 0);
        exp_q.delete();
        repeat (12) @(negedge usbclk);
    endtask

    // A-side ready driver and scoreboard monitor
    bit rand_ready = 1'b0;
    bit ready_force = 1'b1;
    bit mon_en = 1'b1;

    initial forever begin
        @(negedge usbclk);
        a_ready = rand_ready ? ($urandom_range(0, 3) != 0) : ready_force;
    end

    initial begin : monitor
        bit stall_prev = 1'b0;
        logic [17:0] stall_val = '0;
        logic [16:0] e;
        forever begin
            @(negedge usbclk); #2;
            if (!usbrst && mon_en) begin
                if (stall_prev && a_valid)
                    check("hold_stable", {a_press, a_repeat, a_code, a_mod}, stall_val);
                stall_prev = a_valid && !a_ready;
                stall_val  = {a_press, a_repeat, a_code, a_mod};
                if (a_valid && a_ready) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_event actual=press%0d code%0h required=none",
                                 a_press, a_code);
                    end else begin
                        e = exp_q.pop_front();
                        check("event_press_code_mod", {a_press, a_code, a_mod}, e);
                        check("event_repeat", a_repeat, 1'b0);
                    end
                end
            end else begin
                stall_prev = 1'b0;
            end
        end
    end

    function automatic logic [7:0] rand_key();
        int r = $urandom_range(0, 39);
        if (r < 14) return 8'd0;
        if (r == 39) return 8'($urandom_range(1, 3));
        return 8'(4 + r % 6);
    endfunction

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1);
    end

    initial begin : stim
        bit any_valid;
        repeat (3) @(negedge usbclk);
        #2;
        check("rst_valid", a_valid, 1'b0);
        check("rst_fields", {a_press, a_repeat, a_code, a_mod}, 18'd0);
        check("rst_overflow", a_ovf, 1'b0);
        check("rst_b_valid", {b_valid, b_ovf, b_repeat}, 3'd0);
        @(negedge usbclk);
        usbrst = 1'b0;
        repeat (3) @(negedge usbclk);

        // press then release of a single key
        send(0, 2'd1, 8'h02, 32'h0000_0004, 1'b1);
        drain();
        send(0, 2'd1, 8'h00, 32'h0000_0000, 1'b1);
        drain();

        // {04,05} -> {05,06}: release 04, press 06
        send(0, 2'd1, 8'h00, 32'h0000_0504, 1'b1);
        drain();
        send(0, 2'd1, 8'h11, 32'h0000_0605, 1'b1);
        drain();

        // rollover report ignored; next report diffs against {05,06}
        send(0, 2'd1, 8'h00, 32'h0000_0701, 1'b1);
        drain();
        send(0, 2'd1, 8'h40, 32'h0000_0004, 1'b1);
        drain();

        // non-keyboard type ignored; duplicate key pressed once
        send(0, 2'd2, 8'h00, 32'h0909_0909, 1'b1);
        drain();
        send(0, 2'd1, 8'h00, 32'h0008_0808, 1'b1);
        drain();

        // back-to-back reports: the middle one is overwritten while pending
        send(0, 2'd1, 8'h01, 32'h0000_0A09, 1'b1);
        send(0, 2'd1, 8'h02, 32'h0000_0B0B, 1'b0);
        send(0, 2'd1, 8'h04, 32'h0C00_000A, 1'b1);
        drain();

        // random reports with random consumer back-pressure
        rand_ready = 1'b1;
        for (int n = 0; n < 40; n++)  begin
            send(0, ($urandom_range(0, 9) == 0) ? 2'd3 : 2'd1, 8'($urandom),
                 {rand_key(), rand_key(), rand_key(), rand_key()}, 1'b1);
            drain();
        end
        rand_ready = 1'b0;
        check("a_no_overflow", a_ovf, 1'b0);

        // reset in the middle of the press scan
        send(0, 2'd1, 8'h00, 32'h0000_0000, 1'b1);
        drain();
        mon_en = 1'b0;
        ready_force = 1'b0;
        @(negedge usbclk);
        {key4, key3, key2, key1} = 32'h0706_0504;
        typ = 2'd1;
        a_report = 1'b1;
        @(negedge usbclk);
        a_report = 1'b0;
        repeat (6) @(negedge usbclk);
        #1;
        check("pre_rst_valid", a_valid, 1'b1);
        usbrst = 1'b1;
        @(negedge usbclk); #2;
        check("midscan_rst_valid", a_valid, 1'b0);
        @(negedge usbclk);
        usbrst = 1'b0;
        any_valid = 1'b0;
        repeat (20) begin
            @(negedge usbclk); #2;
            if (a_valid) any_valid = 1'b1;
        end
        check("post_rst_quiet", any_valid, 1'b0);
        m_prev = '{default: 8'd0};
        exp_q.delete();
        ready_force = 1'b1;
        mon_en = 1'b1;
        send(0, 2'd1, 8'h05, 32'h0000_0004, 1'b1);
        drain();

        // overflow on a 2-deep FIFO with the consumer stalled
        send(1, 2'd1, 8'h00, 32'h0706_0504, 1'b0);
        repeat (15) @(negedge usbclk);
        #2;
        check("b_overflow_set", b_ovf, 1'b1);
        check("b_head_first", {b_valid, b_press, b_code}, {1'b1, 1'b1, 8'h04});
        b_ovf_clr = 1'b1;
        @(negedge usbclk);
        b_ovf_clr = 1'b0;
        #2;
        check("b_overflow_clr", b_ovf, 1'b0);
        b_ready = 1'b1;
        @(negedge usbclk);
        b_ready = 1'b0;
        #2;
        check("b_head_second", {b_valid, b_press, b_code}, {1'b1, 1'b1, 8'h05});
        b_ready = 1'b1;
        @(negedge usbclk);
        b_ready = 1'b0;
        #2;
        check("b_empty_after", b_valid, 1'b0);

`ifdef HID_KEY_REPEAT_EN
        begin : repeat_test
            int n = 0;
            int rel_idx = -1;
            send(2, 2'd1, 8'h00, 32'h0000_0004, 1'b0);
            while (c_t.size() < 4 && n < 200) begin
                @(negedge usbclk);
                n++;
            end
            check("rpt_count", (c_t.size() >= 4), 1'b1);
            if (c_t.size() >= 4) begin
                check("rpt_first_press", c_e[0], {2'b10, 8'h04});
                check("rpt_first_rpt", c_e[1], {2'b11, 8'h04});
                check("rpt_delay_gap", c_t[1] - c_t[0], 20);
                check("rpt_rate_gap1", c_t[2] - c_t[1], 5);
                check("rpt_rate_gap2", c_t[3] - c_t[2], 5);
                check("rpt_third_rpt", c_e[3], {2'b11, 8'h04});
            end
            send(2, 2'd1, 8'h00, 32'h0000_0000, 1'b0);
            repeat (60) @(negedge usbclk);
            for (int i = 0; i < c_e.size(); i++) if (c_e[i] == {2'b00, 8'h04}) rel_idx = i;
            check("rpt_release_last", rel_idx, c_e.size() - 1);
        end
`endif

        check("a_final_idle", a_valid, 1'b0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/hid_key_events.md
HID_KEY_EVENTS -- requirements
Module: hid_key_events

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 8, event FIFO entries (power of 2, 2..32).
REQ-002 SHALL have parameter REPEAT_DELAY, default 6000000, clocks from press to first repeat (500 ms at 12 MHz).
REQ-003 SHALL have parameter REPEAT_RATE, default 400000, clocks between repeats (30 Hz at 12 MHz).
REQ-004 SHALL have port usbclk  input  1  sole clock, USB 12 MHz domain.
REQ-005 SHALL have port usbrst  input  1  reset, synchronous to usbclk, active-high.
REQ-006 SHALL have port report  input  1  one-cycle strobe, new HID report valid.
REQ-007 SHALL have port typ  input  2  device type; only 1 (keyboard) is processed.
REQ-008 SHALL have ports key_modifiers, key1, key2, key3, key4  input  8 each  boot-protocol keyboard fields, sampled on report.
REQ-009 SHALL have port ev_valid  output  1  event available at FIFO head.
REQ-010 SHALL have port ev_ready  input  1  consumer accepts head when ev_valid && ev_ready.
REQ-011 SHALL have ports ev_press (1), ev_repeat (1), ev_code (8), ev_mod (8)  output  head event: press/release, auto-repeat flag, scancode, modifiers at generation.
REQ-012 SHALL have port overflow  output  1  sticky; an event was dropped.
REQ-013 SHALL have port ovf_clr  input  1  one-cycle clear of overflow.

Function
REQ-014 SHALL capture key1..key4 and key_modifiers into a pending register on report && typ==1; other typ values are ignored.
REQ-015 SHALL discard a report entirely (no events, prev set unchanged) if any keyN is 0x01, 0x02 or 0x03 (rollover/error).
REQ-016 SHALL run FSM IDLE -> REL (4 cycles, prev index 0..3) -> PRS (4 cycles, new index 0..3) -> COMMIT (1 cycle, prev <= new) -> IDLE; leaves IDLE the cycle after capture.
REQ-017 SHALL in REL push release (ev_press=0) for each nonzero prev key absent from the new set.
REQ-018 SHALL in PRS push press (ev_press=1) for each nonzero new key absent from prev and not equal to a lower-indexed new key.
REQ-019 SHALL order events: all releases, then presses, each in ascending index order; pushed event visible on ev_valid the cycle after push.
REQ-020 SHALL, for a report arriving while not IDLE, hold it pending (one deep, latest overwrites) and start it directly after COMMIT.
REQ-021 SHALL on push to a full FIFO drop the event and set overflow, unless a pop occurs the same cycle, in which case the push succeeds.
REQ-022 SHALL give ovf_clr priority below a same-cycle overflow set (set wins).
REQ-023 SHALL hold ev_* stable while ev_valid && !ev_ready.

Reset
REQ-024 SHALL on usbrst: FSM IDLE, FIFO empty, ev_valid=0, ev_press=0, ev_repeat=0, ev_code=0, ev_mod=0, overflow=0, prev set all zero, pending cleared, repeat timer idle.
REQ-025 SHALL abort any in-progress scan on usbrst with no further pushes.

Configuration
REQ-026 SHALL implement auto-repeat only when macro HID_KEY_REPEAT_EN is defined; without it ev_repeat is constant 0 and no timer logic exists.
REQ-027 SHALL with HID_KEY_REPEAT_EN: last pushed non-repeat press becomes repeat key, timer loads REPEAT_DELAY; on expiry push press with ev_repeat=1, current modifiers, reload REPEAT_RATE.
REQ-028 SHALL cancel repeat when the repeat key is released; restart it on any new press.
REQ-029 SHALL defer a repeat push while the FSM is in REL/PRS; it is pushed on the first IDLE cycle.

Structure
REQ-030 SHALL place in shared package hid_pkg: typ constants (NONE=0, KBD=1, MOUSE=2, GAMEPAD=3), rollover codes 0x01..0x03, event record width (18 bits).
REQ-031 SHALL instantiate one sub-module hid_evt_fifo (synchronous FIFO, FIFO_DEPTH x 18, first-word fall-through).

Verification
REQ-032 SHALL test: report key1=0x04 then key1=0 -> press 0x04, then release 0x04, ev_repeat=0.
REQ-033 SHALL test: prev {0x04,0x05}, report {0x05,0x06} -> exactly release 0x04 then press 0x06.
REQ-034 SHALL test: key1=0x01 with key2=0x07 -> no events, next normal report diffs against old prev.
REQ-035 SHALL test: FIFO_DEPTH=2, ev_ready=0, report with 4 new keys -> 2 events kept (first two), overflow=1; ovf_clr -> 0.
REQ-036 SHALL test: HID_KEY_REPEAT_EN, REPEAT_DELAY=20, REPEAT_RATE=5, hold 0x04 -> press, repeats at +20 and every +5 clocks; release stops them.
REQ-037 SHALL test: usbrst asserted mid-PRS -> ev_valid=0 next cycle, no further events, clean operation after release.
